// File: rtl/gate_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_arb_pkg : shared FSM state type and gate opcodes            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package gate_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

endpackage
`default_nettype wire

// File: rtl/gate_arb_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_arb_rr_pick : combinational round-robin winner selection    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module gate_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  function automatic int wrap_idx(input int v);
    return (v >= NUM_REQ) ? (v - NUM_REQ) : v;
  endfunction

  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ID_W'(wrap_idx(int'(ptr) + i))]) begin
        winner = ID_W'(wrap_idx(int'(ptr) + i));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gate_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_arbiter : round-robin sequencer for a shared registered gate |
// | Optional GATE_ARB_OPSEL_EN adds OP port and AND/OR/XOR/NAND.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ*W-1:0] OPA,
  input  logic [NUM_REQ*W-1:0] OPB,
`ifdef GATE_ARB_OPSEL_EN
  input  logic [NUM_REQ*2-1:0] OP,
`endif
  output logic [NUM_REQ-1:0]   GNT,
  output logic                 BUSY,
  output logic                 RES_VALID,
  output logic [ID_W-1:0]      RES_ID,
  output logic [W-1:0]         RESULT
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [W-1:0]         opa_q, opa_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [W-1:0]         res_q, res_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [W-1:0]         gate_out;
  logic [ID_W-1:0]      pick_win;
  logic                 pick_any;
  logic [W-1:0]         opa_arr [NUM_REQ];
  logic [W-1:0]         opb_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opa_arr[g] = OPA[g*W +: W];
    assign opb_arr[g] = OPB[g*W +: W];
  end

  gate_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .winner  (pick_win),
    .any_req (pick_any)
  );

`ifdef GATE_ARB_OPSEL_EN
  logic [1:0] op_q, op_d;
  logic [1:0] op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_op_unpack
    assign op_arr[g] = OP[g*2 +: 2];
  end

  always_comb begin
    op_d = op_q;
    if (state_q == LOAD) op_d = op_arr[win_q];
  end

  always_ff @(posedge CLK) begin
    if (RST) op_q <= OP_AND;
    else     op_q <= op_d;
  end

  always_comb begin
    case (op_q)
      OP_OR:   gate_out = opa_q | opb_q;
      OP_XOR:  gate_out = opa_q ^ opb_q;
      OP_NAND: gate_out = ~(opa_q & opb_q);
      default: gate_out = opa_q & opb_q;
    endcase
  end
`else
  assign gate_out = opa_q & opb_q;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = '0;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (pick_any) begin
          state_d = LOAD;
          win_d   = pick_win;
          gnt_d   = NUM_REQ'(1) << pick_win;
        end
      end
      LOAD: begin
        state_d = EXEC;
        opa_d   = opa_arr[win_q];
        opb_d   = opb_arr[win_q];
        ptr_d   = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      EXEC: begin
        state_d  = RESP;
        res_d    = gate_out;
        res_id_d = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  assign GNT       = gnt_q;
  assign BUSY      = (state_q != IDLE);
  assign RES_VALID = (state_q == RESP);
  assign RES_ID    = res_id_q;
  assign RESULT    = res_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gate_arbiter : directed self-checking bench for gate_arbiter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_gate_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 8;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] opa;
  logic [NUM_REQ*W-1:0] opb;
  logic [NUM_REQ*2-1:0] op;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 res_valid;
  logic [ID_W-1:0]      res_id;
  logic [W-1:0]         result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W       (W),
    .ID_W    (ID_W)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .OPA       (opa),
    .OPB       (opb),
`ifdef GATE_ARB_OPSEL_EN
    .OP        (op),
`endif
    .GNT       (gnt),
    .BUSY      (busy),
    .RES_VALID (res_valid),
    .RES_ID    (res_id),
    .RESULT    (result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_res;
    int         exp_id;
    rst = 1'b1;
    req = '0;
    opa = '0;
    opb = '0;
    op  = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    // Idle with no requests
    step();
    step();
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);

    // Single request from requester 1 (ptr 0 -> 2)
    req = 4'b0010;
    opa[1*W +: W] = 8'hF0;
    opb[1*W +: W] = 8'h3C;
    step();
    chk("single_gnt", gnt, 4'b0010);
    chk("single_busy_load", busy, 1);
    chk("single_valid_load", res_valid, 0);
    req = '0;
    step();
    chk("single_gnt_exec", gnt, 0);
    chk("single_busy_exec", busy, 1);
    chk("single_valid_exec", res_valid, 0);
    step();
    chk("single_valid", res_valid, 1);
    chk("single_busy_resp", busy, 1);
    chk("single_id", res_id, 1);
    chk("single_result", result, 8'h30);
    step();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_valid", res_valid, 0);
    chk("single_hold_result", result, 8'h30);
    chk("single_hold_id", res_id, 1);

    // Operand change after grant (ptr 2 -> requester 0 still wins, ptr -> 1)
    req = 4'b0001;
    opa[0 +: W] = 8'hFF;
    opb[0 +: W] = 8'h0F;
    step();
    chk("opchg_gnt", gnt, 4'b0001);
    req = '0;
    step();
    opa[0 +: W] = 8'h00;
    step();
    chk("opchg_valid", res_valid, 1);
    chk("opchg_id", res_id, 0);
    chk("opchg_result", result, 8'h0F);
    step();

    // Short pulse from 3, then requester 0 raised during RESP
    req = 4'b1000;
    opa[3*W +: W] = 8'h5A;
    opb[3*W +: W] = 8'hFF;
    opa[0 +: W]   = 8'h77;
    opb[0 +: W]   = 8'h33;
    step();
    chk("pulse_gnt3", gnt, 4'b1000);
    req = '0;
    step();
    step();
    chk("pulse_valid3", res_valid, 1);
    chk("pulse_id3", res_id, 3);
    chk("pulse_result3", result, 8'h5A);
    req = 4'b0001;
    step();
    chk("pulse_gnt0", gnt, 4'b0001);
    chk("pulse_busy_load", busy, 1);
    req = '0;
    step();
    step();
    chk("pulse_valid0", res_valid, 1);
    chk("pulse_id0", res_id, 0);
    chk("pulse_result0", result, 8'h33);
    step();

    // Reset asserted during EXEC discards the operation
    req = 4'b0100;
    opa[2*W +: W] = 8'hFF;
    opb[2*W +: W] = 8'hFF;
    step();
    chk("rstx_gnt", gnt, 4'b0100);
    req = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstx_gnt0", gnt, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_valid", res_valid, 0);
    chk("rstx_id", res_id, 0);
    chk("rstx_result", result, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstx_no_valid", res_valid, 0);
    end

    // All four held continuously after reset: grants 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) begin
      opa[i*W +: W] = 8'(8'h11 * (i + 1));
      opb[i*W +: W] = 8'hFF;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id  = k % NUM_REQ;
      exp_res = 8'(8'h11 * (exp_id + 1));
      step();
      chk("rr_gnt", gnt, 32'(4'b0001 << exp_id));
      chk("rr_load_valid", res_valid, 0);
      step();
      chk("rr_exec_gnt", gnt, 0);
      step();
      chk("rr_valid", res_valid, 1);
      chk("rr_id", res_id, exp_id);
      chk("rr_result", result, exp_res);
    end
    req = '0;
    step();
    chk("rr_end_busy", busy, 0);

`ifdef GATE_ARB_OPSEL_EN
    // Opcode sweep on requester 1 with AA/CC
    opa[1*W +: W] = 8'hAA;
    opb[1*W +: W] = 8'hCC;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       exp_res = 8'h88;
        1:       exp_res = 8'hEE;
        2:       exp_res = 8'h66;
        default: exp_res = 8'h77;
      endcase
      op[1*2 +: 2] = 2'(k);
      req = 4'b0010;
      step();
      chk("opsel_gnt", gnt, 4'b0010);
      req = '0;
      step();
      step();
      chk("opsel_valid", res_valid, 1);
      chk("opsel_result", result, exp_res);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
